// File: rtl/led_blink_bank.sv
// Bank of LEDs showing a binary count whose tick rate is picked by debounced buttons; switches gate each LED.
// Latency: sw->led 3 clk, btn edge->period load 2+DEB_CYCLES+1 clk; no backpressure, outputs free-run.
module led_blink_bank #(
  parameter int N_CH        = 4,
  parameter int N_BTN       = 4,
  parameter int CNT_W       = 28,
  parameter int BASE_PERIOD = 100000000,
  parameter int DEB_CYCLES  = 1000000
) (
  input  logic             CLK100MHZ,
  input  logic             ck_rst,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_CH-1:0]  sw,
  output logic [N_CH-1:0]  led
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [N_BTN-1:0] btn_meta;
  logic [N_BTN-1:0] btn_sync;
  logic [N_CH-1:0]  sw_meta;
  logic [N_CH-1:0]  sw_sync;

  logic [DEB_W-1:0] deb_cnt [N_BTN];
  logic [N_BTN-1:0] btn_stable;
  logic [N_BTN-1:0] btn_stable_q;
  logic [N_BTN-1:0] press;

  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_sel;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0]  phase;
  logic             tick;

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  // Each button flips its stable state only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      btn_stable   <= '0;
      btn_stable_q <= '0;
      for (int i = 0; i < N_BTN; i++) deb_cnt[i] <= '0;
    end else begin
      btn_stable_q <= btn_stable;
      for (int i = 0; i < N_BTN; i++) begin
        if (btn_sync[i] != btn_stable[i]) begin
          if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
            btn_stable[i] <= btn_sync[i];
            deb_cnt[i]    <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = btn_stable & ~btn_stable_q;

  // Descending scan so the lowest-index pressed button has the final say.
  always_comb begin
    period_sel = period;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press[i]) period_sel = CNT_W'(BASE_PERIOD >> i);
    end
  end

  assign tick = (cnt == period - CNT_W'(1));

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      period <= CNT_W'(BASE_PERIOD);
      cnt    <= '0;
      phase  <= '0;
    end else if (|press) begin
      period <= period_sel;
      cnt    <= '0;
      phase  <= '0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + N_CH'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Phase keeps counting with a switch off, so re-enabling shows the live count.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      led <= '0;
    end else begin
      led <= sw_sync & phase;
    end
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Randomized and directed bench for led_blink_bank with an event-level reference model.
module tb_led_blink_bank;

  localparam int N_CH  = 4;
  localparam int N_BTN = 4;
  localparam int CNT_W = 8;
  localparam int BASE  = 16;
  localparam int DEB   = 4;

  logic             CLK100MHZ = 1'b0;
  logic             ck_rst    = 1'b1;
  logic [N_BTN-1:0] btn       = '0;
  logic [N_CH-1:0]  sw        = '0;
  logic [N_CH-1:0]  led;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  led_blink_bank #(
    .N_CH(N_CH), .N_BTN(N_BTN), .CNT_W(CNT_W), .BASE_PERIOD(BASE), .DEB_CYCLES(DEB)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .ck_rst(ck_rst),
    .btn(btn),
    .sw(sw),
    .led(led)
  );

  // Reference model: inputs seen two edges late, phase = edges since restart / period,
  // a press is accepted once the last DEB synced samples all read 1 while stable is 0.
  logic [N_CH-1:0]  m_sw1, m_sw2, m_led;
  logic [N_BTN-1:0] m_b1, m_b2, m_stable, m_pulse;
  int               m_period;
  int               m_elapsed;
  logic [N_BTN-1:0] hist[$];

  function automatic logic [N_CH-1:0] m_phase();
    return N_CH'((m_elapsed / m_period) % (1 << N_CH));
  endfunction

  always @(posedge CLK100MHZ or negedge ck_rst) begin : model
    logic [N_BTN-1:0] nxt_pulse;
    int ones;
    int k;
    if (!ck_rst) begin
      m_sw1 = '0; m_sw2 = '0; m_b1 = '0; m_b2 = '0;
      m_stable = '0; m_pulse = '0; m_led = '0;
      m_period = BASE; m_elapsed = 0;
      hist.delete();
    end else begin
      m_led = m_sw2 & m_phase();
      if (m_pulse != '0) begin
        k = 0;
        for (int i = N_BTN - 1; i >= 0; i--) if (m_pulse[i]) k = i;
        m_period  = BASE >> k;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
      hist.push_back(m_b2);
      if (hist.size() > DEB) void'(hist.pop_front());
      nxt_pulse = '0;
      if (hist.size() == DEB) begin
        for (int i = 0; i < N_BTN; i++) begin
          ones = 0;
          foreach (hist[j]) if (hist[j][i]) ones++;
          if (ones == DEB && !m_stable[i]) begin
            m_stable[i]  = 1'b1;
            nxt_pulse[i] = 1'b1;
          end else if (ones == 0 && m_stable[i]) begin
            m_stable[i] = 1'b0;
          end
        end
      end
      m_pulse = nxt_pulse;
      m_sw2 = m_sw1; m_sw1 = sw;
      m_b2 = m_b1;   m_b1 = btn;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK100MHZ) begin
    if (run_cmp) begin
      check("led_vs_model", 32'(led), 32'(m_led));
      check("period_vs_model", 32'(dut.period), m_period);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w;
    int hold;
    sw = 4'hF;
    btn = '0;
    #3 ck_rst = 1'b0;
    run_cmp = 1'b1;
    repeat (3) @(negedge CLK100MHZ);
    check("led_in_reset", 32'(led), 0);
    check("period_in_reset", 32'(dut.period), BASE);
    ck_rst = 1'b1;

    // Free-running at base period: led[0] rises after edge 17, count 2 at edge 33, count 8 at edge 129.
    repeat (16) @(posedge CLK100MHZ);
    #2 check("led_edge16", 32'(led), 0);
    @(posedge CLK100MHZ);
    #2 check("led_edge17", 32'(led), 32'h1);
    repeat (16) @(posedge CLK100MHZ);
    #2 check("led_edge33", 32'(led), 32'h2);
    repeat (96) @(posedge CLK100MHZ);
    #2 check("led_edge129", 32'(led), 32'h8);

    // btn[2] held: period 4 loaded on the 7th edge, counters restarted.
    @(negedge CLK100MHZ) btn = 4'b0100;
    repeat (6) @(posedge CLK100MHZ);
    #2 check("period_before_load", 32'(dut.period), BASE);
    @(posedge CLK100MHZ);
    #2 check("period_btn2", 32'(dut.period), 4);
    check("cnt_after_press", 32'(dut.cnt), 0);
    check("phase_after_press", 32'(dut.phase), 0);
    repeat (3) @(negedge CLK100MHZ);
    btn = '0;
    repeat (20) @(negedge CLK100MHZ);

    // Short glitch is ignored.
    btn = 4'b0001;
    repeat (3) @(negedge CLK100MHZ);
    btn = '0;
    repeat (12) @(negedge CLK100MHZ);
    check("period_after_glitch", 32'(dut.period), 4);

    // Simultaneous btn[1] and btn[3]: lowest index wins.
    btn = 4'b1010;
    repeat (7) @(posedge CLK100MHZ);
    #2 check("period_lowest_wins", 32'(dut.period), 8);
    repeat (5) @(negedge CLK100MHZ);
    btn = '0;
    repeat (12) @(negedge CLK100MHZ);

    // Switch off while led[0] is lit, then back on.
    w = 0;
    while (led[0] !== 1'b1 && w < 100) begin
      @(negedge CLK100MHZ);
      w++;
    end
    check("led0_lit_seen", 32'(led[0]), 1);
    sw = 4'b1110;
    repeat (3) @(posedge CLK100MHZ);
    #2 check("led0_sw_off", 32'(led[0]), 0);
    @(negedge CLK100MHZ) sw = 4'hF;
    repeat (10) @(negedge CLK100MHZ);

    // Period 2, then asynchronous reset mid-period.
    btn = 4'b1000;
    repeat (7) @(posedge CLK100MHZ);
    #2 check("period_btn3", 32'(dut.period), 2);
    @(negedge CLK100MHZ) btn = '0;
    repeat (3) @(posedge CLK100MHZ);
    #2 ck_rst = 1'b0;
    #1 check("led_async_rst", 32'(led), 0);
    check("period_async_rst", 32'(dut.period), BASE);
    @(negedge CLK100MHZ) ck_rst = 1'b1;
    @(posedge CLK100MHZ);
    #2 check("cnt_first_edge", 32'(dut.cnt), 1);

    // Reset in the middle of a debounce: full delay again after release.
    @(negedge CLK100MHZ) btn = 4'b0010;
    repeat (4) @(posedge CLK100MHZ);
    #2 ck_rst = 1'b0;
    @(negedge CLK100MHZ) ck_rst = 1'b1;
    repeat (6) @(posedge CLK100MHZ);
    #2 check("period_deb_restart_e6", 32'(dut.period), BASE);
    @(posedge CLK100MHZ);
    #2 check("period_deb_restart_e7", 32'(dut.period), 8);
    @(negedge CLK100MHZ) btn = '0;

    // Random traffic: switch flips, button holds of mixed length, occasional async reset.
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK100MHZ);
      if ($urandom_range(0, 99) < 10) sw = N_CH'($urandom);
      if (hold == 0) begin
        btn  = ($urandom_range(0, 2) == 0) ? N_BTN'($urandom) : '0;
        hold = $urandom_range(1, 10);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 ck_rst = 1'b0;
        @(negedge CLK100MHZ) ck_rst = 1'b1;
      end
    end

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_blink_bank.md
LED_BLINK_BANK -- requirements
Module: led_blink_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of LED/switch channels (1..8).
REQ-002 SHALL have parameter N_BTN, default 4: number of rate-select buttons (1..8).
REQ-003 SHALL have parameter CNT_W, default 28: period counter width.
REQ-004 SHALL have parameter BASE_PERIOD, default 100000000: tick period in clocks for rate index 0; must satisfy BASE_PERIOD >> (N_BTN-1) >= 2 and BASE_PERIOD < 2^CNT_W.
REQ-005 SHALL have parameter DEB_CYCLES, default 1000000: consecutive stable cycles required to accept a button change (>= 1).
REQ-006 SHALL have port CLK100MHZ, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have port ck_rst, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port btn, input, N_BTN: raw asynchronous rate-select buttons, active-high.
REQ-009 SHALL have port sw, input, N_CH: raw asynchronous channel enables, active-high.
REQ-010 SHALL have port led, output, N_CH: registered LED drives, active-high.

Function
REQ-011 SHALL pass each btn and sw bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL debounce each synchronized btn bit independently: stable state changes only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; any cycle of agreement clears that bit's debounce count.
REQ-013 SHALL generate a one-cycle press pulse per button on a stable 0->1 transition; 1->0 transitions generate nothing.
REQ-014 SHALL, on any press pulse, load period with BASE_PERIOD >> k, where k is the lowest-index button pulsing that cycle.
REQ-015 SHALL, in the cycle after a press pulse, have cnt = 0 and phase = 0 (restart, no partial period).
REQ-016 SHALL keep period unchanged while buttons are held or released; only new presses change it.
REQ-017 SHALL increment the CNT_W-bit cnt every cycle without a press pulse; when cnt == period-1, cnt SHALL return to 0 and a one-cycle tick SHALL fire, giving exactly period clocks between ticks.
REQ-018 SHALL hold an N_CH-bit phase counter that increments on each tick and wraps from 2^N_CH-1 to 0.
REQ-019 SHALL give a press pulse priority over a coincident tick: cnt and phase clear and phase does not increment.
REQ-020 SHALL register led[i] <= sw_sync[i] & phase[i] every cycle, so channel i toggles every 2^i ticks (binary-count display).
REQ-021 SHALL have a switch-to-LED latency of 3 clocks: 2 synchronizer stages plus 1 output register.
REQ-022 SHALL have a press-to-period-load latency of 2 + DEB_CYCLES + 1 clocks from a clean btn rising edge held stable.
REQ-023 SHALL keep a channel with its switch off at led = 0 while its phase bit continues counting, so re-enabling shows the current phase.

Reset
REQ-024 SHALL, on ck_rst low, asynchronously clear all synchronizer flops, debounce counts, stable states, cnt, phase and led to 0, and set period to BASE_PERIOD.
REQ-025 SHALL release reset cleanly: the first cnt increment occurs on the first rising edge with ck_rst high.
REQ-026 SHALL, when reset is asserted mid-period or mid-debounce, abandon all progress; a press in progress then needs the full DEB_CYCLES after release.

Verification (N_CH=4, N_BTN=4, BASE_PERIOD=16, DEB_CYCLES=4, CNT_W=8)
REQ-027 SHALL pass this scenario: reset, sw=4'b1111, no buttons -> led[0] toggles every 16 clocks, led[1] every 32, led[3] every 128; led = 0 throughout reset.
REQ-028 SHALL pass this scenario: btn[2] held high 10 cycles -> period = 4 loaded 7 clocks after the edge; cnt and phase = 0 the next cycle; led[0] toggles every 4 clocks thereafter.
REQ-029 SHALL pass this scenario: btn glitch high for 3 cycles (< DEB_CYCLES) -> period unchanged and no phase restart.
REQ-030 SHALL pass this scenario: btn[1] and btn[3] rise in the same cycle and are held -> period = 8 (lowest index wins).
REQ-031 SHALL pass this scenario: sw[0] 1->0 while led[0] = 1 -> led[0] = 0 exactly 3 clocks later; sw[0] back to 1 shows the current phase[0] after 3 clocks.
REQ-032 SHALL pass this scenario: ck_rst pulsed low mid-period with period = 2 -> led = 0 and period = 16 immediately (asynchronously); counting restarts from 0 after release.
